// File: rtl/fsquare.sv
// fsquare -- pipelined single-precision squarer (x*x), truncating, sign forced to 0.
//
// Three register stages with a single global advance:
//   S1 unpack  : biased exponent, mantissa with hidden one, zero/inf-nan class
//   S2 multiply: 24x24 -> 48-bit mantissa product
//   S3 pack    : normalize, exponent 2e-127+norm, special-case override
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset, clears every stage
//   in_valid   in   in_data carries an operand
//   in_ready   out  operand accepted this cycle (= ~out_valid | out_ready)
//   in_data    in   [31:0] IEEE-754 single operand
//   out_valid  out  out_data carries a result
//   out_ready  in   consumer takes the result this cycle
//   out_data   out  [31:0] result
//   out_flags  out  [2:0] {ovf, unf, inv}, only when FSQUARE_FLAGS_EN is defined
//
// Optional feature macro: FSQUARE_FLAGS_EN (adds out_flags and its pipeline registers).

module fsquare (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef FSQUARE_FLAGS_EN
  ,
  output logic [2:0]  out_flags
`endif
);

  // Stage 1 registers
  logic        s1_valid;
  logic        s1_zero;
  logic        s1_inf;
  logic [7:0]  s1_exp;
  logic [23:0] s1_mant;

  // Stage 2 registers
  logic        s2_valid;
  logic        s2_zero;
  logic        s2_inf;
  logic [7:0]  s2_exp;
  logic [47:0] s2_prod;

  // Stage 3 combinational results
  logic        norm;
  logic [22:0] mant;
  logic signed [9:0] eo;
  logic [31:0] data_next;
`ifdef FSQUARE_FLAGS_EN
  logic [2:0]  flags_next;
`endif

  logic        adv;

  // The sign never reaches the result and the low product bits fall below the
  // truncation point; both are tapped here only so they read as intentionally unused.
  logic        sign_unused;
  logic [22:0] prod_lo_unused;
  assign sign_unused    = in_data[31];
  assign prod_lo_unused = s2_prod[22:0];

  // One advance for the whole pipe: a result can always move on if the output
  // slot is empty or is being drained this cycle.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Normalize and pack. Specials win over the regular path, zero input first.
  always_comb begin
    norm      = s2_prod[47];
    mant      = norm ? s2_prod[46:24] : s2_prod[45:23];
    eo        = $signed({1'b0, s2_exp, 1'b0}) - 10'sd127 + $signed({9'd0, norm});
    data_next = {1'b0, eo[7:0], mant};
`ifdef FSQUARE_FLAGS_EN
    flags_next = 3'b000;
`endif
    if (s2_zero) begin
      data_next = 32'h0000_0000;
    end else if (s2_inf) begin
      data_next = 32'h7F80_0000;
`ifdef FSQUARE_FLAGS_EN
      flags_next = 3'b001;
`endif
    end else if (eo >= 10'sd255) begin
      data_next = 32'h7F80_0000;
`ifdef FSQUARE_FLAGS_EN
      flags_next = 3'b100;
`endif
    end else if (eo <= 10'sd0) begin
      data_next = 32'h0000_0000;
`ifdef FSQUARE_FLAGS_EN
      flags_next = 3'b010;
`endif
    end
  end

  // Pipeline registers: everything shifts together on adv, everything holds otherwise.
  // Bubbles travel as ordinary entries with valid=0 so they never collapse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_inf    <= 1'b0;
      s1_exp    <= 8'd0;
      s1_mant   <= 24'd0;
      s2_valid  <= 1'b0;
      s2_zero   <= 1'b0;
      s2_inf    <= 1'b0;
      s2_exp    <= 8'd0;
      s2_prod   <= 48'd0;
      out_valid <= 1'b0;
      out_data  <= 32'h0000_0000;
`ifdef FSQUARE_FLAGS_EN
      out_flags <= 3'b000;
`endif
    end else if (adv) begin
      s1_valid  <= in_valid & in_ready;
      s1_zero   <= (in_data[30:23] == 8'h00);
      s1_inf    <= (in_data[30:23] == 8'hFF);
      s1_exp    <= in_data[30:23];
      s1_mant   <= {1'b1, in_data[22:0]};
      s2_valid  <= s1_valid;
      s2_zero   <= s1_zero;
      s2_inf    <= s1_inf;
      s2_exp    <= s1_exp;
      s2_prod   <= s1_mant * s1_mant;
      out_valid <= s2_valid;
      out_data  <= data_next;
`ifdef FSQUARE_FLAGS_EN
      out_flags <= flags_next;
`endif
    end
  end

endmodule

// File: tb/tb_fsquare.sv
// tb_fsquare -- self-checking bench for fsquare.
//
// A scoreboard queue receives the expected result whenever an operand is
// accepted and is compared when a result is taken. Table vectors carry
// hand-computed expectations; random operands use a reference model.
// Flags are compared only when FSQUARE_FLAGS_EN is defined.

module tb_fsquare;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef FSQUARE_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  fsquare dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FSQUARE_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flags;
    int          tcyc;
    bit          chk_lat;
  } sb_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic [2:0]  flags;
  } vec_t;

  sb_t         sb_q[$];
  sb_t         mon_e;
  vec_t        tbl[14];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          outputs_seen = 0;
  bit          lat_mode = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [31:0] pend_data;
  logic [2:0]  pend_flags;

  always @(posedge clk) cyc <= cyc + 1;

  // Random back-pressure, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Independent reference: {flags, data} of x*x with truncation.
  function automatic logic [34:0] ref_model(input logic [31:0] x);
    int e;
    int n;
    int eo;
    longint unsigned ma;
    longint unsigned p;
    logic [22:0] man;
    e  = int'(x[30:23]);
    ma = longint'({1'b1, x[22:0]});
    p  = ma * ma;
    if (e == 0)   return {3'b000, 32'h0000_0000};
    if (e == 255) return {3'b001, 32'h7F80_0000};
    n   = (p >= (64'd1 << 47)) ? 1 : 0;
    man = (n == 1) ? 23'(p >> 24) : 23'(p >> 23);
    eo  = 2 * e - 127 + n;
    if (eo >= 255) return {3'b100, 32'h7F80_0000};
    if (eo <= 0)   return {3'b010, 32'h0000_0000};
    return {3'b000, 1'b0, 8'(eo), man};
  endfunction

  // Monitor: pop/compare on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        outputs_seen++;
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("sb_data", out_data, mon_e.data);
`ifdef FSQUARE_FLAGS_EN
          checkOutput("sb_flags", {29'd0, out_flags}, {29'd0, mon_e.flags});
`endif
          if (mon_e.chk_lat) checkOutput("latency", cyc - mon_e.tcyc, 32'd3);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back('{data: pend_data, flags: pend_flags, tcyc: cyc, chk_lat: lat_mode});
      end
    end
  end

  // Present one operand; returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] exp_d, input logic [2:0] exp_f);
    bit ok;
    int n;
    in_valid   = 1'b1;
    in_data    = x;
    pend_data  = exp_d;
    pend_flags = exp_f;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) checkOutput("drain_timeout", sb_q.size(), 32'd0);
    #1;
  endtask

  initial begin
    int base;
    logic [31:0] x;
    logic [34:0] r;

    tbl[0]  = '{32'h4040_0000, 32'h4110_0000, 3'b000};
    tbl[1]  = '{32'hC000_0000, 32'h4080_0000, 3'b000};
    tbl[2]  = '{32'h3FC0_0000, 32'h4010_0000, 3'b000};
    tbl[3]  = '{32'h7F00_0000, 32'h7F80_0000, 3'b100};
    tbl[4]  = '{32'h1F80_0000, 32'h0000_0000, 3'b010};
    tbl[5]  = '{32'h7FC0_0000, 32'h7F80_0000, 3'b001};
    tbl[6]  = '{32'h8000_0000, 32'h0000_0000, 3'b000};
    tbl[7]  = '{32'h0040_0000, 32'h0000_0000, 3'b000};
    tbl[8]  = '{32'h3F80_0000, 32'h3F80_0000, 3'b000};
    tbl[9]  = '{32'h5F7F_FFFF, 32'h7F7F_FFFE, 3'b000};
    tbl[10] = '{32'h5F80_0000, 32'h7F80_0000, 3'b100};
    tbl[11] = '{32'h2000_0000, 32'h0080_0000, 3'b000};
    tbl[12] = '{32'h1FFF_FFFF, 32'h0000_0000, 3'b010};
    tbl[13] = '{32'hFF80_0000, 32'h7F80_0000, 3'b001};

    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    pend_data = 32'd0; pend_flags = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'h0000_0000);
`ifdef FSQUARE_FLAGS_EN
    checkOutput("rst_out_flags", {29'd0, out_flags}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back table vectors with out_ready held high; latency checked.
    $display("[TB] table vectors");
    out_ready = 1'b1;
    lat_mode  = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(tbl[i].din, tbl[i].dout, tbl[i].flags);
    drain();
    lat_mode = 1'b0;

    // Stall with the first result parked in the output register.
    $display("[TB] stall sequence");
    applyStimulus(32'h3F80_0000, 32'h3F80_0000, 3'b000);
    applyStimulus(32'h4000_0000, 32'h4080_0000, 3'b000);
    out_ready = 1'b0;
    applyStimulus(32'h4040_0000, 32'h4110_0000, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall_out_data", out_data, 32'h3F80_0000);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with two operands in flight, one of them already at the output.
    $display("[TB] reset mid-operation");
    out_ready = 1'b0;
    applyStimulus(32'h4040_0000, 32'h4110_0000, 3'b000);
    applyStimulus(32'h4000_0000, 32'h4080_0000, 3'b000);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    base = outputs_seen;
    rst = 1'b1;
    sb_q.delete();
    #1;
    checkOutput("rst_flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_flush_out_data", out_data, 32'h0000_0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("in_ready_after_rst2", {31'd0, in_ready}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("no_output_after_rst", outputs_seen - base, 32'd0);

    // Random operands with random gaps and random back-pressure.
    $display("[TB] random traffic");
    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      x = $urandom;
      r = ref_model(x);
      applyStimulus(x, r[31:0], r[34:32]);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    checkOutput("sb_leftover", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
